// File: rtl/sdram_scheduler_if.sv
// Command/request bundle between the frame-buffer scheduler and its neighbours:
// camera/display request levels in, SDRAM engine command handshake out.
interface sdram_scheduler_if #(
    parameter int ADDR_WIDTH = 22
);
    logic                  wr_req;
    logic                  wr_frame_start;
    logic                  rd_req;
    logic                  rd_frame_start;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_done;
    logic                  wr_grant;
    logic                  rd_grant;
    logic                  refresh_overflow;
    logic                  busy;

    modport master (
        input  wr_req, wr_frame_start, rd_req, rd_frame_start, cmd_ready, cmd_done,
        output cmd_valid, cmd_op, cmd_addr, wr_grant, rd_grant, refresh_overflow, busy
    );

    modport slave (
        output wr_req, wr_frame_start, rd_req, rd_frame_start, cmd_ready, cmd_done,
        input  cmd_valid, cmd_op, cmd_addr, wr_grant, rd_grant, refresh_overflow, busy
    );
endinterface

// File: rtl/sdram_scheduler.sv
// Arbitrates the shared SDRAM frame buffer between camera writes, display reads and
// auto-refresh; one burst command in flight at a time.
module sdram_scheduler #(
    parameter int ADDR_WIDTH         = 22,
    parameter int BURST_LEN          = 8,
    parameter int FRAME_WORDS        = 153600,
    parameter int REFRESH_INTERVAL   = 375,
    parameter int MAX_REFRESH_DEBT   = 8,
    parameter int WRITE_STARVE_LIMIT = 16
) (
    input  logic              sdram_clk,
    input  logic              reset_n,
    sdram_scheduler_if.master bus
);
    localparam int AW = ADDR_WIDTH;
    localparam int TW = $clog2(REFRESH_INTERVAL);
    localparam int DW = $clog2(MAX_REFRESH_DEBT + 1);
    localparam int SW = $clog2(WRITE_STARVE_LIMIT + 1);

    localparam logic [1:0] OP_NONE = 2'd0, OP_RD = 2'd1, OP_WR = 2'd2, OP_REF = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   wr_addr_q, rd_addr_q;
    logic [TW-1:0]   tmr_q;
    logic [DW-1:0]   debt_q;
    logic [SW-1:0]   skip_q;
    logic            ovf_q;

    logic hs, tick, ref_done, debt_max;

    assign hs       = (state_q == S_ISSUE) && bus.cmd_ready;
    assign tick     = (tmr_q == TW'(REFRESH_INTERVAL - 1));
    assign ref_done = (state_q == S_WAIT) && bus.cmd_done && (op_q == OP_REF);
    assign debt_max = (debt_q == DW'(MAX_REFRESH_DEBT));

    function automatic logic [AW-1:0] adv(input logic [AW-1:0] a);
        logic [AW-1:0] n;
        n = a + AW'(BURST_LEN);
        return (n == AW'(FRAME_WORDS)) ? '0 : n;
    endfunction

    always_ff @(posedge sdram_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_NONE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
        end
    end

    // Requests are only looked at in IDLE; the chosen op/addr stay frozen until done.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        unique case (state_q)
            S_IDLE: begin
                op_d   = OP_NONE;
                addr_d = '0;
                if (debt_max) begin
                    op_d = OP_REF;
                end else if (bus.wr_req && (skip_q >= SW'(WRITE_STARVE_LIMIT))) begin
                    op_d   = OP_WR;
                    addr_d = wr_addr_q;
                end else if (bus.rd_req) begin
                    op_d   = OP_RD;
                    addr_d = rd_addr_q;
                end else if (bus.wr_req) begin
                    op_d   = OP_WR;
                    addr_d = wr_addr_q;
                end else if (debt_q != '0) begin
                    op_d = OP_REF;
                end
                state_d = (op_d != OP_NONE) ? S_ISSUE : S_IDLE;
            end
            S_ISSUE: if (bus.cmd_ready) state_d = S_WAIT;
            S_WAIT:  if (bus.cmd_done)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_valid        = (state_q == S_ISSUE);
        bus.cmd_op           = (state_q == S_ISSUE) ? op_q : OP_NONE;
        bus.cmd_addr         = (state_q == S_ISSUE) ? addr_q : '0;
        bus.wr_grant         = hs && (op_q == OP_WR);
        bus.rd_grant         = hs && (op_q == OP_RD);
        bus.busy             = (state_q != S_IDLE);
        bus.refresh_overflow = ovf_q;
    end

    always_ff @(posedge sdram_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            tmr_q     <= '0;
            debt_q    <= '0;
            skip_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            // A frame start overrides the post-handshake advance.
            if (bus.wr_frame_start)         wr_addr_q <= '0;
            else if (hs && op_q == OP_WR)   wr_addr_q <= adv(wr_addr_q);
            if (bus.rd_frame_start)         rd_addr_q <= '0;
            else if (hs && op_q == OP_RD)   rd_addr_q <= adv(rd_addr_q);

            tmr_q <= tick ? '0 : tmr_q + 1'b1;

            unique case ({tick, ref_done})
                2'b10:   if (!debt_max)      debt_q <= debt_q + 1'b1;
                2'b01:   if (debt_q != '0)   debt_q <= debt_q - 1'b1;
                default: ;
            endcase
            if (tick && debt_max) ovf_q <= 1'b1;

            if (hs && op_q == OP_WR)
                skip_q <= '0;
            else if (hs && op_q == OP_RD && bus.wr_req && skip_q < SW'(WRITE_STARVE_LIMIT))
                skip_q <= skip_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_sdram_scheduler.sv
// Directed bench for sdram_scheduler: a cycle table for the basic handshake plus
// sequences for starvation, frame restart, refresh deadlines, wrap and overflow.
module tb_sdram_scheduler;
    localparam int AW = 22;
    localparam int FW = 153600;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sdram_scheduler_if #(.ADDR_WIDTH(AW)) bus ();

    sdram_scheduler #(
        .ADDR_WIDTH(AW), .BURST_LEN(8), .FRAME_WORDS(FW),
        .REFRESH_INTERVAL(375), .MAX_REFRESH_DEBT(8), .WRITE_STARVE_LIMIT(16)
    ) dut (
        .sdram_clk(clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Handshake monitor with an independent address model.
    int          cyc = 0, nref = 0, first_ref_cyc = 0, n_rd = 0;
    logic [AW-1:0] exp_rd = '0, exp_wr = '0, last_rd = '0;
    logic [1:0]  ops[$];
    logic [AW-1:0] wq[$];

    always @(negedge clk) begin
        logic hs;
        #2;
        if (!reset_n) begin
            cyc = 0; nref = 0; first_ref_cyc = 0; n_rd = 0;
            exp_rd = '0; exp_wr = '0;
            ops.delete(); wq.delete();
        end else begin
            cyc++;
            hs = bus.cmd_valid && bus.cmd_ready;
            if (hs || bus.rd_grant || bus.wr_grant)
                chk("grant", {62'd0, bus.wr_grant, bus.rd_grant},
                    {62'd0, hs && bus.cmd_op == 2'd2, hs && bus.cmd_op == 2'd1});
            if (hs) begin
                ops.push_back(bus.cmd_op);
                case (bus.cmd_op)
                    2'd1: begin
                        chk("rd_addr", 64'(bus.cmd_addr), 64'(exp_rd));
                        last_rd = bus.cmd_addr;
                        n_rd++;
                        exp_rd = (exp_rd + 8 == FW) ? '0 : exp_rd + 8;
                    end
                    2'd2: begin
                        chk("wr_addr", 64'(bus.cmd_addr), 64'(exp_wr));
                        wq.push_back(bus.cmd_addr);
                        exp_wr = (exp_wr + 8 == FW) ? '0 : exp_wr + 8;
                    end
                    default: begin
                        chk("ref_addr", 64'(bus.cmd_addr), 64'd0);
                        nref++;
                        if (first_ref_cyc == 0) first_ref_cyc = cyc;
                    end
                endcase
            end
            if (bus.rd_frame_start) exp_rd = '0;
            if (bus.wr_frame_start) exp_wr = '0;
        end
    end

    typedef struct {
        logic rd, wr, rdy, done;
        logic vld; logic [1:0] op; logic [AW-1:0] addr; logic wg, rg, busy;
    } vec_t;

    vec_t vt[20];

    function automatic logic [27:0] outs();
        return {bus.cmd_valid, bus.cmd_op, bus.cmd_addr, bus.wr_grant, bus.rd_grant, bus.busy};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus.rd_req = 0; bus.wr_req = 0; bus.cmd_ready = 0; bus.cmd_done = 0;
        bus.rd_frame_start = 0; bus.wr_frame_start = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [1:0] h_op;
        logic [AW-1:0] h_addr;
        int bad, k, nw;
        bus.rd_req = 0; bus.wr_req = 0; bus.cmd_ready = 0; bus.cmd_done = 0;
        bus.rd_frame_start = 0; bus.wr_frame_start = 0;

        //          rd wr rdy dn  vld op addr wg rg busy
        vt[0]  = '{0, 0, 0, 0,  0, 0, 0,  0, 0, 0};
        vt[1]  = '{1, 0, 1, 1,  0, 0, 0,  0, 0, 0};
        vt[2]  = '{1, 0, 1, 1,  1, 1, 0,  0, 1, 1};
        vt[3]  = '{1, 0, 1, 1,  0, 0, 0,  0, 0, 1};
        vt[4]  = '{1, 0, 1, 1,  0, 0, 0,  0, 0, 0};
        vt[5]  = '{1, 0, 1, 1,  1, 1, 8,  0, 1, 1};
        vt[6]  = '{1, 1, 1, 1,  0, 0, 0,  0, 0, 1};
        vt[7]  = '{1, 1, 1, 1,  0, 0, 0,  0, 0, 0};
        vt[8]  = '{0, 1, 1, 1,  1, 1, 16, 0, 1, 1};
        vt[9]  = '{0, 1, 1, 1,  0, 0, 0,  0, 0, 1};
        vt[10] = '{0, 1, 1, 1,  0, 0, 0,  0, 0, 0};
        vt[11] = '{0, 0, 1, 1,  1, 2, 0,  1, 0, 1};
        vt[12] = '{0, 0, 1, 0,  0, 0, 0,  0, 0, 1};
        vt[13] = '{0, 0, 1, 1,  0, 0, 0,  0, 0, 1};
        vt[14] = '{1, 0, 0, 1,  0, 0, 0,  0, 0, 0};
        vt[15] = '{1, 0, 0, 1,  1, 1, 24, 0, 0, 1};
        vt[16] = '{1, 0, 1, 0,  1, 1, 24, 0, 1, 1};
        vt[17] = '{0, 0, 1, 1,  0, 0, 0,  0, 0, 1};
        vt[18] = '{0, 0, 1, 1,  0, 0, 0,  0, 0, 0};
        vt[19] = '{0, 0, 0, 0,  0, 0, 0,  0, 0, 0};

        do_reset();
        chk("reset_ovf", 64'(bus.refresh_overflow), 64'd0);
        for (int i = 0; i < 20; i++) begin
            bus.rd_req = vt[i].rd; bus.wr_req = vt[i].wr;
            bus.cmd_ready = vt[i].rdy; bus.cmd_done = vt[i].done;
            #1;
            chk($sformatf("vec%0d", i), 64'(outs()),
                64'({vt[i].vld, vt[i].op, vt[i].addr, vt[i].wg, vt[i].rg, vt[i].busy}));
            @(negedge clk);
        end

        // cmd_ready held low for 10 cycles in ISSUE
        do_reset();
        bus.rd_req = 1; bus.cmd_done = 1;
        k = 0;
        while (!bus.cmd_valid && k < 10) begin @(negedge clk); k++; end
        #1;
        h_op = bus.cmd_op; h_addr = bus.cmd_addr;
        chk("hold_cmd", 64'({bus.cmd_valid, h_op, h_addr}), 64'({1'b1, 2'd1, 22'd0}));
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (!bus.cmd_valid || bus.cmd_op != h_op || bus.cmd_addr != h_addr || bus.rd_grant) bad++;
        end
        chk("hold_stable", 64'(bad), 64'd0);
        bus.cmd_ready = 1; #1;
        chk("hold_grant", 64'(bus.rd_grant), 64'd1);

        // Write starvation bound
        do_reset();
        bus.rd_req = 1; bus.wr_req = 1; bus.cmd_ready = 1; bus.cmd_done = 1;
        k = 0;
        while (ops.size() < 34 && k < 300) begin @(negedge clk); k++; end
        chk("starve_timeout", 64'(ops.size() >= 34), 64'd1);
        bad = 0;
        for (int i = 0; i < 34 && i < ops.size(); i++)
            if (ops[i] != ((i == 16 || i == 33) ? 2'd2 : 2'd1)) bad++;
        chk("starve_pat", 64'(bad), 64'd0);
        chk("starve_waddr", 64'({wq.size() > 1 ? wq[0] : 22'h3fffff, wq.size() > 1 ? wq[1] : 22'h3fffff}),
            64'({22'd0, 22'd8}));

        // Frame start coincident with the WRITE handshake at addr 40
        do_reset();
        bus.wr_req = 1; bus.cmd_ready = 1; bus.cmd_done = 1;
        k = 0;
        while (k < 100) begin
            @(negedge clk); #1; k++;
            if (bus.cmd_valid && bus.cmd_op == 2'd2 && bus.cmd_addr == 22'd40) begin
                bus.wr_frame_start = 1;
                @(negedge clk);
                bus.wr_frame_start = 0;
                break;
            end
        end
        k = 0;
        while (wq.size() < 7 && k < 50) begin @(negedge clk); k++; end
        nw = wq.size();
        chk("fs_count", 64'(nw >= 7), 64'd1);
        if (nw >= 7) chk("fs_addr", 64'({wq[5], wq[6]}), 64'({22'd40, 22'd0}));

        // Idle: one refresh per interval, debt repaid
        do_reset();
        bus.cmd_ready = 1; bus.cmd_done = 1;
        repeat (400) @(negedge clk);
        chk("idle_ref1", 64'(nref), 64'd1);
        repeat (300) @(negedge clk);
        chk("idle_ref_once", 64'(nref), 64'd1);

        // Continuous reads: refresh deferred to debt 8, address wraps after 19200 bursts
        do_reset();
        bus.rd_req = 1; bus.cmd_ready = 1; bus.cmd_done = 1;
        k = 0;
        while (n_rd < 19201 && k < 60000) begin @(negedge clk); k++; end
        chk("wrap_timeout", 64'(n_rd), 64'd19201);
        chk("rd_wrap", 64'(last_rd), 64'd0);
        chk("ref_preempt", 64'(first_ref_cyc >= 3001 && first_ref_cyc <= 3007), 64'd1);

        // cmd_done withheld: overflow on the 9th tick, then async reset mid-WAIT_DONE
        do_reset();
        bus.cmd_ready = 1; bus.cmd_done = 0;
        repeat (3370) @(negedge clk);
        chk("ovf_before", 64'(bus.refresh_overflow), 64'd0);
        repeat (10) @(negedge clk);
        chk("ovf_set", 64'({bus.refresh_overflow, bus.busy, bus.cmd_valid}), 64'b110);
        repeat (120) @(negedge clk);
        chk("ovf_sticky", 64'(bus.refresh_overflow), 64'd1);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst", 64'({outs(), bus.refresh_overflow}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
